// File: rtl/collatz_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : collatz_driver_if
// Description : Job, kernel and result signal bundle for collatz_driver.
//               Adds out_cycles when COLLATZ_DRIVER_LATENCY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface collatz_driver_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_n;
  logic        kern_rst_n;
  logic        kern_start;
  logic [31:0] kern_n;
  logic        kern_finish;
  logic [31:0] kern_ret;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_n;
  logic [31:0] out_steps;
  logic        out_timeout;
  logic        busy;
`ifdef COLLATZ_DRIVER_LATENCY_EN
  logic [31:0] out_cycles;
`endif

  // Driver-side view
  modport master (
    input  in_valid, in_n, kern_finish, kern_ret, out_ready,
    output in_ready, kern_rst_n, kern_start, kern_n,
           out_valid, out_n, out_steps, out_timeout, busy
`ifdef COLLATZ_DRIVER_LATENCY_EN
    , output out_cycles
`endif
  );

  // Environment-side view (job source, kernel, result sink)
  modport slave (
    output in_valid, in_n, kern_finish, kern_ret, out_ready,
    input  in_ready, kern_rst_n, kern_start, kern_n,
           out_valid, out_n, out_steps, out_timeout, busy
`ifdef COLLATZ_DRIVER_LATENCY_EN
    , input out_cycles
`endif
  );
endinterface
`default_nettype wire

// File: rtl/collatz_driver.sv
`default_nettype none
// ============================================================================
// Module      : collatz_driver
// Description : Sequences one Collatz kernel job at a time: kernel reset,
//               start pulse, bounded run with timeout, held result.
//               Optional out_cycles output via COLLATZ_DRIVER_LATENCY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module collatz_driver #(
  parameter int unsigned KRST_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input wire               clk,
  input wire               rst,
  collatz_driver_if.master bus
);

  localparam logic [1:0]  c_IDLE      = 2'd0;
  localparam logic [1:0]  c_KRST      = 2'd1;
  localparam logic [1:0]  c_RUN       = 2'd2;
  localparam logic [1:0]  c_OUT       = 2'd3;
  localparam logic [31:0] c_KRST_LAST = 32'(KRST_CYCLES - 1);
  localparam logic [31:0] c_TIMEOUT   = 32'(TIMEOUT_CYCLES);

  logic [1:0]  state_q,       state_d;
  logic [31:0] krst_cnt_q,    krst_cnt_d;
  logic [31:0] run_cnt_q,     run_cnt_d;
  logic        kern_rst_n_q,  kern_rst_n_d;
  logic        kern_start_q,  kern_start_d;
  logic [31:0] kern_n_q,      kern_n_d;
  logic        out_valid_q,   out_valid_d;
  logic [31:0] out_n_q,       out_n_d;
  logic [31:0] out_steps_q,   out_steps_d;
  logic        out_timeout_q, out_timeout_d;
  logic        busy_q,        busy_d;
`ifdef COLLATZ_DRIVER_LATENCY_EN
  logic [31:0] out_cycles_q,  out_cycles_d;
`endif

  logic [31:0] w_run_inc;
  logic        w_fin_qual;
  logic        w_timeout;

  assign w_run_inc  = (run_cnt_q == 32'hFFFF_FFFF) ? run_cnt_q : run_cnt_q + 32'd1;
  // The start cycle still sees the kernel's stale finish flop, so it is masked.
  assign w_fin_qual = bus.kern_finish & ~kern_start_q;
  assign w_timeout  = (w_run_inc >= c_TIMEOUT);

  always_comb begin
    state_d       = state_q;
    krst_cnt_d    = krst_cnt_q;
    run_cnt_d     = run_cnt_q;
    kern_rst_n_d  = kern_rst_n_q;
    kern_start_d  = 1'b0;
    kern_n_d      = kern_n_q;
    out_valid_d   = out_valid_q;
    out_n_d       = out_n_q;
    out_steps_d   = out_steps_q;
    out_timeout_d = out_timeout_q;
`ifdef COLLATZ_DRIVER_LATENCY_EN
    out_cycles_d  = out_cycles_q;
`endif

    case (state_q)
      c_IDLE: begin
        kern_rst_n_d = 1'b1;
        if (bus.in_valid) begin
          state_d      = c_KRST;
          kern_n_d     = bus.in_n;
          out_n_d      = bus.in_n;
          krst_cnt_d   = 32'd0;
          kern_rst_n_d = 1'b0;
        end
      end
      c_KRST: begin
        kern_rst_n_d = 1'b0;
        krst_cnt_d   = krst_cnt_q + 32'd1;
        if (krst_cnt_q == c_KRST_LAST) begin
          state_d      = c_RUN;
          kern_start_d = 1'b1;
          kern_rst_n_d = 1'b1;
          run_cnt_d    = 32'd0;
        end
      end
      c_RUN: begin
        kern_rst_n_d = 1'b1;
        run_cnt_d    = w_run_inc;
        if (w_fin_qual) begin
          state_d       = c_OUT;
          out_valid_d   = 1'b1;
          out_steps_d   = bus.kern_ret;
          out_timeout_d = 1'b0;
`ifdef COLLATZ_DRIVER_LATENCY_EN
          out_cycles_d  = w_run_inc;
`endif
        end else if (w_timeout) begin
          // Hold the abandoned kernel in reset until the result is taken.
          state_d       = c_OUT;
          out_valid_d   = 1'b1;
          out_steps_d   = 32'd0;
          out_timeout_d = 1'b1;
          kern_rst_n_d  = 1'b0;
`ifdef COLLATZ_DRIVER_LATENCY_EN
          out_cycles_d  = w_run_inc;
`endif
        end
      end
      c_OUT: begin
        if (bus.out_ready) begin
          state_d      = c_IDLE;
          out_valid_d  = 1'b0;
          kern_rst_n_d = 1'b1;
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase

    busy_d = (state_d != c_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= c_IDLE;
      krst_cnt_q    <= 32'd0;
      run_cnt_q     <= 32'd0;
      kern_rst_n_q  <= 1'b0;
      kern_start_q  <= 1'b0;
      kern_n_q      <= 32'd0;
      out_valid_q   <= 1'b0;
      out_n_q       <= 32'd0;
      out_steps_q   <= 32'd0;
      out_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef COLLATZ_DRIVER_LATENCY_EN
      out_cycles_q  <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      krst_cnt_q    <= krst_cnt_d;
      run_cnt_q     <= run_cnt_d;
      kern_rst_n_q  <= kern_rst_n_d;
      kern_start_q  <= kern_start_d;
      kern_n_q      <= kern_n_d;
      out_valid_q   <= out_valid_d;
      out_n_q       <= out_n_d;
      out_steps_q   <= out_steps_d;
      out_timeout_q <= out_timeout_d;
      busy_q        <= busy_d;
`ifdef COLLATZ_DRIVER_LATENCY_EN
      out_cycles_q  <= out_cycles_d;
`endif
    end
  end

  assign bus.in_ready    = (state_q == c_IDLE);
  assign bus.kern_rst_n  = kern_rst_n_q;
  assign bus.kern_start  = kern_start_q;
  assign bus.kern_n      = kern_n_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_n       = out_n_q;
  assign bus.out_steps   = out_steps_q;
  assign bus.out_timeout = out_timeout_q;
  assign bus.busy        = busy_q;
`ifdef COLLATZ_DRIVER_LATENCY_EN
  assign bus.out_cycles  = out_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_collatz_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_collatz_driver
// Description : Directed bench: real-kernel model on one driver, stub kernel
//               on a second driver with TIMEOUT_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collatz_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  collatz_driver_if u_if ();
  collatz_driver_if u_if_t ();

  collatz_driver #(.KRST_CYCLES(2), .TIMEOUT_CYCLES(65535)) u_dut (
    .clk (clk), .rst (rst), .bus (u_if.master)
  );
  collatz_driver #(.KRST_CYCLES(2), .TIMEOUT_CYCLES(4)) u_dut_t (
    .clk (clk), .rst (rst), .bus (u_if_t.master)
  );

  // Behavioural Collatz kernel: step count until n reaches 1, sticky finish
  logic [31:0] k_n, k_cnt;
  logic        k_fin, k_act;
  always @(posedge clk) begin
    if (!u_if.kern_rst_n) begin
      k_n <= 32'd0; k_cnt <= 32'd0; k_fin <= 1'b0; k_act <= 1'b0;
    end else if (u_if.kern_start) begin
      k_n   <= u_if.kern_n;
      k_cnt <= 32'd0;
      k_fin <= (u_if.kern_n <= 32'd1);
      k_act <= (u_if.kern_n > 32'd1);
    end else if (k_act) begin
      if (k_n == 32'd1) begin
        k_fin <= 1'b1; k_act <= 1'b0;
      end else begin
        k_n   <= k_n[0] ? (k_n * 32'd3 + 32'd1) : (k_n >> 1);
        k_cnt <= k_cnt + 32'd1;
      end
    end
  end
  assign u_if.kern_finish = k_fin;
  assign u_if.kern_ret    = k_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  logic [31:0] r_n, r_steps;
  logic        r_to, r_got;
  int          r_starts, r_start_at, r_krst_low, r_bad, r_bad_hold;

  // One job on the real-kernel driver; out_ready is held low for `hold` cycles
  // after out_valid first appears.
  task do_job(input logic [31:0] n, input int hold);
    r_starts = 0; r_start_at = -1; r_krst_low = 0; r_bad = 0; r_bad_hold = 0; r_got = 0;
    @(negedge clk);
    u_if.in_valid = 1'b1; u_if.in_n = n; u_if.out_ready = (hold == 0);
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      u_if.in_valid = 1'b0;
      if (u_if.kern_start) begin r_starts++; r_start_at = k; end
      if (!u_if.kern_rst_n && r_starts == 0) r_krst_low++;
      if (u_if.in_ready || !u_if.busy) r_bad++;
      if (u_if.out_valid) begin
        r_got = 1'b1; r_n = u_if.out_n; r_steps = u_if.out_steps; r_to = u_if.out_timeout;
        break;
      end
    end
    if (r_got) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!u_if.out_valid || u_if.in_ready || u_if.out_n !== r_n ||
            u_if.out_steps !== r_steps || u_if.out_timeout !== r_to) r_bad_hold++;
      end
      u_if.out_ready = 1'b1;
      @(negedge clk);
      if (u_if.out_valid || !u_if.in_ready || u_if.busy) r_bad_hold++;
    end
  endtask

  int seen, outs;

  initial begin
    u_if.in_valid = 1'b0; u_if.in_n = 32'd0; u_if.out_ready = 1'b0;
    u_if_t.in_valid = 1'b0; u_if_t.in_n = 32'd0; u_if_t.out_ready = 1'b0;
    u_if_t.kern_finish = 1'b0; u_if_t.kern_ret = 32'd0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready",   u_if.in_ready, 1);
    check_eq("rst_kern_rst_n", u_if.kern_rst_n, 0);
    check_eq("rst_kern_start", u_if.kern_start, 0);
    check_eq("rst_out_valid",  u_if.out_valid, 0);
    check_eq("rst_busy",       u_if.busy, 0);
    check_eq("rst_out_steps",  u_if.out_steps, 0);
    check_eq("rst_kern_n",     u_if.kern_n, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_kern_rst_n", u_if.kern_rst_n, 1);

    // n=6 -> 8 steps, start KRST_CYCLES+1 after accept
    do_job(32'd6, 0);
    check_eq("j6_got",      r_got, 1);
    check_eq("j6_out_n",    r_n, 6);
    check_eq("j6_steps",    r_steps, 8);
    check_eq("j6_timeout",  r_to, 0);
    check_eq("j6_starts",   r_starts, 1);
    check_eq("j6_start_at", r_start_at, 3);
    check_eq("j6_krst_low", r_krst_low, 2);
    check_eq("j6_ready",    r_bad, 0);
    check_eq("j6_hshake",   r_bad_hold, 0);

    // Back-to-back 1, 27, 0
    do_job(32'd1, 0);
    check_eq("j1_steps", r_steps, 0);
    check_eq("j1_ready", r_bad, 0);
    do_job(32'd27, 0);
    check_eq("j27_steps", r_steps, 111);
    check_eq("j27_out_n", r_n, 27);
    check_eq("j27_ready", r_bad, 0);
    do_job(32'd0, 0);
    check_eq("j0_steps", r_steps, 0);
    check_eq("j0_got",   r_got, 1);
    check_eq("j0_ready", r_bad, 0);

    // Back-pressure: result held for 10 cycles
    do_job(32'd6, 10);
    check_eq("bp_steps", r_steps, 8);
    check_eq("bp_hold",  r_bad_hold, 0);

    // Timeout on the stub driver: RUN is accept+3..accept+6, result at +7
    seen = -1;
    @(negedge clk);
    u_if_t.in_valid = 1'b1; u_if_t.in_n = 32'd9; u_if_t.out_ready = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      u_if_t.in_valid = 1'b0;
      if (u_if_t.out_valid) begin seen = k; break; end
    end
    check_eq("to_at",         seen, 7);
    check_eq("to_timeout",    u_if_t.out_timeout, 1);
    check_eq("to_steps",      u_if_t.out_steps, 0);
    check_eq("to_out_n",      u_if_t.out_n, 9);
    check_eq("to_kern_rst_n", u_if_t.kern_rst_n, 0);
`ifdef COLLATZ_DRIVER_LATENCY_EN
    check_eq("to_cycles",     u_if_t.out_cycles, 4);
`endif
    u_if_t.out_ready = 1'b1;
    @(negedge clk);
    check_eq("to_done_valid", u_if_t.out_valid, 0);
    check_eq("to_done_ready", u_if_t.in_ready, 1);
    u_if_t.out_ready = 1'b0;

    // Finish on the timeout cycle wins; finish in KRST and start cycle ignored
    seen = -1;
    @(negedge clk);
    u_if_t.in_valid = 1'b1; u_if_t.in_n = 32'd3;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      u_if_t.in_valid = 1'b0;
      if (u_if_t.out_valid) begin seen = k; break; end
      u_if_t.kern_finish = (k <= 3) || (k == 6);
      u_if_t.kern_ret    = (k == 6) ? 32'd5 : 32'd77;
    end
    u_if_t.kern_finish = 1'b0;
    check_eq("ft_at",         seen, 7);
    check_eq("ft_steps",      u_if_t.out_steps, 5);
    check_eq("ft_timeout",    u_if_t.out_timeout, 0);
    check_eq("ft_kern_rst_n", u_if_t.kern_rst_n, 1);
`ifdef COLLATZ_DRIVER_LATENCY_EN
    check_eq("ft_cycles",     u_if_t.out_cycles, 4);
`endif
    u_if_t.out_ready = 1'b1;
    @(negedge clk);
    u_if_t.out_ready = 1'b0;

    // Reset mid-RUN aborts the job
    seen = -1;
    @(negedge clk);
    u_if.in_valid = 1'b1; u_if.in_n = 32'd27; u_if.out_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      u_if.in_valid = 1'b0;
      if (u_if.kern_start) begin seen = k; break; end
    end
    check_eq("mr_start", seen, 3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mr_out_valid",  u_if.out_valid, 0);
    check_eq("mr_busy",       u_if.busy, 0);
    check_eq("mr_kern_rst_n", u_if.kern_rst_n, 0);
    check_eq("mr_kern_n",     u_if.kern_n, 0);
    check_eq("mr_out_n",      u_if.out_n, 0);
    check_eq("mr_in_ready",   u_if.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    outs = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (u_if.out_valid) outs++;
    end
    check_eq("mr_no_result", outs, 0);
    do_job(32'd6, 0);
    check_eq("mr_next_steps",    r_steps, 8);
    check_eq("mr_next_start_at", r_start_at, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/collatz_driver.md
COLLATZ_DRIVER -- requirements
Module: collatz_driver

Interface
REQ-001 SHALL have parameter KRST_CYCLES, default 2: number of cycles kern_rst_n is held low before each job (min 1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum number of RUN cycles before a job is abandoned (min 1).
REQ-003 One clock; reset is asynchronous and active-high. clk  in  1  clock; all state is captured on the rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 in_valid  in  1  job request valid.
REQ-006 in_ready  out  1  driver can accept a job.
REQ-007 in_n  in  32  collatz start value.
REQ-008 kern_rst_n  out  1  kernel synchronous reset, active-low.
REQ-009 kern_start  out  1  kernel start pulse.
REQ-010 kern_n  out  32  operand held for the kernel.
REQ-011 kern_finish  in  1  kernel done.
REQ-012 kern_ret  in  32  kernel step count.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 out_n  out  32  echo of the job operand.
REQ-016 out_steps  out  32  step count; 0 on timeout.
REQ-017 out_timeout  out  1  job was abandoned.
REQ-018 busy  out  1  state is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, KRST, RUN and OUT; only one job is in flight at a time.
REQ-020 IDLE behaviour:
- in_ready=1 and kern_rst_n=1.
- On in_valid&in_ready, latch in_n into kern_n and out_n, load krst_cnt=0, and go to KRST.
REQ-021 KRST behaviour:
- kern_rst_n=0.
- krst_cnt increments each cycle.
- When krst_cnt==KRST_CYCLES-1, go to RUN and drive kern_start=1 for exactly the first RUN cycle.
REQ-022 Accept at cycle T SHALL give kern_rst_n low for T+1..T+KRST_CYCLES and kern_start high at T+KRST_CYCLES+1.
REQ-023 RUN behaviour:
- kern_rst_n=1.
- kern_finish is sampled only from the cycle after kern_start.
- run_cnt (32-bit, saturating) counts RUN cycles, starting at 0 on entry.
REQ-024 RUN completion:
- On a qualified kern_finish=1, capture kern_ret into out_steps, clear out_timeout, and go to OUT; out_valid rises the next cycle.
- If run_cnt reaches TIMEOUT_CYCLES with no qualified finish, set out_steps=0 and out_timeout=1, and go to OUT.
REQ-025 A qualified finish and the timeout in the same cycle SHALL resolve as finish (out_timeout=0).
REQ-026 OUT behaviour:
- out_valid=1; out_n, out_steps and out_timeout are held stable until out_valid&out_ready.
- kern_rst_n=0 after a timeout and 1 after a normal finish.
- On handshake, go to IDLE.
REQ-027 in_ready SHALL be 0 in KRST, RUN and OUT, so no input is accepted until the previous result has been consumed.
REQ-028 Minimum accept-to-accept interval SHALL be KRST_CYCLES+kernel latency+3 cycles with out_ready held at 1.
REQ-029 kern_finish/kern_ret SHALL be ignored outside RUN, because the kernel's finish flop is only cleared under kern_rst_n.
REQ-030 All outputs SHALL be registered; there are no combinational in→out paths except in_ready, which is a decode of the state register.

Reset
REQ-031 Reset values:
- State=IDLE; in_ready=1 after reset is released.
- kern_rst_n=0 while rst=1.
- kern_start=0, out_valid=0, out_timeout=0, busy=0.
- kern_n, out_n, out_steps, run_cnt, krst_cnt = 0.
REQ-032 Reset asserted mid-job SHALL abort the job without emitting a result; the first job after reset release starts again from KRST.

Configuration
REQ-033 Macro COLLATZ_DRIVER_LATENCY_EN, when defined, adds output out_cycles (32 bits): the run_cnt value at completion, registered alongside out_steps, reset value 0, equal to TIMEOUT_CYCLES on timeout.
REQ-034 Without COLLATZ_DRIVER_LATENCY_EN, the out_cycles port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 in_n=6 with the real kernel, out_ready=1 -> one result: out_n=6, out_steps=8, out_timeout=0; kern_start pulses exactly once, KRST_CYCLES+1 cycles after the accept.
REQ-036 Back-to-back jobs 1, 27, 0 -> results out_steps=0, 111, 0 in order; in_ready stays low while each job is in flight.
REQ-037 out_ready=0 for 10 cycles after out_valid rises -> out_valid and data held stable for all 10 cycles, in_ready=0 throughout, then one handshake and return to IDLE.
REQ-038 TIMEOUT_CYCLES=4 with a stub kernel that never finishes -> out_timeout=1, out_steps=0, kern_rst_n low in OUT; out_cycles=4 when the macro is defined.
REQ-039 Stub kernel asserting kern_finish on the exact timeout cycle with kern_ret=5 -> out_steps=5, out_timeout=0; rst pulsed mid-RUN -> no out_valid, all outputs at reset values, and the next job completes normally.
